f_pc_fetch: RTL

- F-stage program-counter and instruction-fetch unit for the 5-stage MIPS pipeline.
- Consumes the redirect target produced by the D-stage next-PC logic (jump/branch target, jr/jalr register value) with MIPS delay-slot semantics.
- Drives a single-outstanding request/response instruction-memory port and hands instr/PC to the F/D pipeline register under hazard-unit stall control.

---
 rtl/f_pc_fetch_pkg.sv | 18 +
 rtl/f_fetch_buf.sv | 32 +++
 rtl/f_pc_fetch.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/f_pc_fetch_pkg.sv
// Shared constants and types for the F-stage fetch unit: FSM encodings,
// reset PC default, the bubble instruction word and an alignment helper.
package f_pc_fetch_pkg;

  typedef enum logic [1:0] {
    F_REQ  = 2'd0,
    F_WAIT = 2'd1,
    F_HOLD = 2'd2
  } f_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/f_fetch_buf.sv
// Hold register for a fetched instruction, its PC and its exception flag,
// used while the hazard unit stalls the F/D register.
module f_fetch_buf
  import f_pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        capture,
  input  logic [31:0] instr_d,
  input  logic [31:0] pc_d,
  input  logic        exc_d,
  output logic [31:0] instr_q,
  output logic [31:0] pc_q,
  output logic        exc_q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= NOP_INSTR;
      pc_q    <= RESET_PC;
      exc_q   <= 1'b0;
    end else if (capture) begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      exc_q   <= exc_d;
    end
  end

endmodule

// File: rtl/f_pc_fetch.sv
// F-stage PC and instruction fetch: single-outstanding imem port, MIPS
// delay-slot redirect handling and stall-aware hand-off to the F/D register.
module f_pc_fetch
  import f_pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        f_valid,
  output logic [31:0] f_instr,
  output logic [31:0] f_pc,
  output logic        f_exc_adel
);

  f_state_e    state, state_next;
  logic [31:0] pc, pending_pc, next_pc;
  logic        pending;
  logic        misaligned, take_redirect, available, advance, capture;
  logic [31:0] word, word_pc;
  logic        word_exc;
  logic [31:0] buf_instr, buf_pc;
  logic        buf_exc;

  f_fetch_buf #(
    .RESET_PC (RESET_PC),
    .NOP_INSTR(NOP_INSTR)
  ) u_buf (
    .clk    (clk),
    .reset  (reset),
    .capture(capture),
    .instr_d(word),
    .pc_d   (word_pc),
    .exc_d  (word_exc),
    .instr_q(buf_instr),
    .pc_q   (buf_pc),
    .exc_q  (buf_exc)
  );

  // A misaligned PC never reaches memory; it yields a NOP tagged with AdEL at once.
  always_comb begin
    misaligned    = is_misaligned(pc[1:0]);
    take_redirect = redirect_valid & ~stall;
    available     = 1'b0;
    word          = NOP_INSTR;
    word_pc       = pc;
    word_exc      = 1'b0;
    case (state)
      F_REQ: begin
        if (misaligned) begin
          available = 1'b1;
          word_exc  = 1'b1;
        end
      end
      F_WAIT: begin
        if (imem_rvalid) begin
          available = 1'b1;
          word      = imem_rdata;
        end
      end
      F_HOLD: begin
        available = 1'b1;
        word      = buf_instr;
        word_pc   = buf_pc;
        word_exc  = buf_exc;
      end
      default: ;
    endcase
    advance = available & ~stall;
    capture = available & stall & (state != F_HOLD);
    next_pc = take_redirect ? redirect_pc : (pending ? pending_pc : pc + 32'd4);
    imem_req  = (state == F_REQ) & ~misaligned & ~reset;
    imem_addr = pc;
  end

  always_comb begin
    state_next = state;
    case (state)
      F_REQ: begin
        if (misaligned) begin
          if (stall) state_next = F_HOLD;
        end else if (imem_gnt) begin
          state_next = F_WAIT;
        end
      end
      F_WAIT: begin
        if (imem_rvalid) state_next = stall ? F_HOLD : F_REQ;
      end
      F_HOLD: begin
        if (!stall) state_next = F_REQ;
      end
      default: state_next = F_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= F_REQ;
    else       state <= state_next;
  end

  // A redirect seen without an advance is parked so the delay slot still completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_PC;
      pending    <= 1'b0;
      pending_pc <= RESET_PC;
    end else if (advance) begin
      pc      <= next_pc;
      pending <= 1'b0;
    end else if (take_redirect) begin
      pending    <= 1'b1;
      pending_pc <= redirect_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f_valid    <= 1'b0;
      f_instr    <= NOP_INSTR;
      f_pc       <= RESET_PC;
      f_exc_adel <= 1'b0;
    end else if (advance) begin
      f_valid    <= 1'b1;
      f_instr    <= word;
      f_pc       <= word_pc;
      f_exc_adel <= word_exc;
    end else if (!stall) begin
      f_valid    <= 1'b0;
      f_instr    <= NOP_INSTR;
      f_exc_adel <= 1'b0;
    end
  end

endmodule
